demux_l2_sched: RTL and testbench



---
 rtl/demux_l2_sched.sv | 115 +++++++++++
 tb/tb_demux_l2_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_l2_sched.sv
// L2 1-to-2 byte demux lane scheduler (clk_4f domain): alternates accepted bytes
// between two per-lane FIFOs and realigns the lane phase to lane 0 after a long idle gap.
module demux_l2_sched #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 2,
  parameter int IDLE_MAX = 15
) (
  input  logic              clk_4f,
  input  logic              reset_L,
  input  logic              valid,
  input  logic [DATA_W-1:0] data_in0_demuxL2,
  output logic              in_ready,
  input  logic              ready0,
  input  logic              ready1,
  output logic              validout0,
  output logic              validout1,
  output logic [DATA_W-1:0] dataout0_demuxL2,
  output logic [DATA_W-1:0] dataout1_demuxL2,
  output logic              lane_sel,
  output logic              err_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [7:0] IDLE_LAST = 8'(IDLE_MAX - 1);

  typedef enum logic [1:0] {S_IDLE, S_L0, S_L1} state_t;

  state_t            state, state_d;
  logic [7:0]        idle_cnt, idle_cnt_d;
  logic [DATA_W-1:0] mem [2][DEPTH];
  logic [PW-1:0]     wr_ptr [2];
  logic [PW-1:0]     rd_ptr [2];
  logic [1:0]        full, empty, push, pop;
  logic              acc;

  // Extra pointer MSB separates full from empty when the low bits match.
  always_comb begin
    full  = '0;
    empty = '0;
    for (int i = 0; i < 2; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][PW-1] != rd_ptr[i][PW-1]) &&
                 (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
    end
  end

  assign lane_sel  = (state == S_L1);
  assign in_ready  = !full[lane_sel];
  assign acc       = valid & in_ready;
  assign push      = acc ? (lane_sel ? 2'b10 : 2'b01) : 2'b00;
  assign validout0 = !empty[0];
  assign validout1 = !empty[1];
  assign pop       = {validout1 & ready1, validout0 & ready0};

  assign dataout0_demuxL2 = empty[0] ? '0 : mem[0][rd_ptr[0][AW-1:0]];
  assign dataout1_demuxL2 = empty[1] ? '0 : mem[1][rd_ptr[1][AW-1:0]];

  // NOTE: storage is left unreset; the empty flag masks stale contents on the outputs.
  always_ff @(posedge clk_4f) begin
    for (int i = 0; i < 2; i++)
      if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= data_in0_demuxL2;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state    <= S_IDLE;
      idle_cnt <= '0;
      err_drop <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      state    <= state_d;
      idle_cnt <= idle_cnt_d;
      if (valid && !in_ready) err_drop <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
  always_comb begin
    state_d    = state;
    idle_cnt_d = idle_cnt;
    case (state)
      S_IDLE: begin
        idle_cnt_d = '0;
        if (acc) state_d = S_L1;
      end
      S_L0, S_L1: begin
        if (valid) begin
          // A dropped byte still counts as activity; only an accept advances the phase.
          idle_cnt_d = '0;
          if (acc) state_d = (state == S_L0) ? S_L1 : S_L0;
        end else if (idle_cnt == IDLE_LAST) begin
          state_d    = S_IDLE;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt + 8'd1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        idle_cnt_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_demux_l2_sched.sv
// Directed self-checking bench for demux_l2_sched with default parameters
// (DATA_W=8, DEPTH=2, IDLE_MAX=15).
module tb_demux_l2_sched;

  logic       clk_4f = 1'b0;
  logic       reset_L, valid, ready0, ready1;
  logic [7:0] data_in0_demuxL2;
  logic       in_ready, validout0, validout1, lane_sel, err_drop;
  logic [7:0] dataout0_demuxL2, dataout1_demuxL2;

  int vectors     = 0;
  int miscompares = 0;

  demux_l2_sched dut (
    .clk_4f           (clk_4f),
    .reset_L          (reset_L),
    .valid            (valid),
    .data_in0_demuxL2 (data_in0_demuxL2),
    .in_ready         (in_ready),
    .ready0           (ready0),
    .ready1           (ready1),
    .validout0        (validout0),
    .validout1        (validout1),
    .dataout0_demuxL2 (dataout0_demuxL2),
    .dataout1_demuxL2 (dataout1_demuxL2),
    .lane_sel         (lane_sel),
    .err_drop         (err_drop)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic tick;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic do_reset;
    reset_L = 1'b0; valid = 1'b0; ready0 = 1'b0; ready1 = 1'b0; data_in0_demuxL2 = '0;
    tick; tick;
    reset_L = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    vectors++;
    if ({validout0, validout1, lane_sel, in_ready, err_drop} !== 5'b00010) begin
      $display("FAIL reset_flags got %b exp 00010", {validout0, validout1, lane_sel, in_ready, err_drop});
      miscompares++;
    end
    vectors++;
    if ({dataout0_demuxL2, dataout1_demuxL2} !== 16'h0000) begin
      $display("FAIL reset_data got %h exp 0000", {dataout0_demuxL2, dataout1_demuxL2});
      miscompares++;
    end
  endtask

  task automatic test_stream;
    logic [7:0] exp, got;
    logic       gv, ov;
    do_reset;
    ready0 = 1'b1; ready1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1; data_in0_demuxL2 = 8'h10 + 8'(i);
      vectors++;
      if (in_ready !== 1'b1) begin
        $display("FAIL stream_in_ready[%0d] got %b exp 1", i, in_ready); miscompares++;
      end
      tick;
      exp = 8'h10 + 8'(i);
      if (i % 2 == 0) begin got = dataout0_demuxL2; gv = validout0; ov = validout1; end
      else            begin got = dataout1_demuxL2; gv = validout1; ov = validout0; end
      vectors++;
      if ({gv, got} !== {1'b1, exp}) begin
        $display("FAIL stream_lane%0d[%0d] got %b/%h exp 1/%h", i % 2, i, gv, got, exp); miscompares++;
      end
      vectors++;
      if (ov !== 1'b0) begin
        $display("FAIL stream_other_lane[%0d] got %b exp 0", i, ov); miscompares++;
      end
      vectors++;
      if (lane_sel !== (i % 2 == 0)) begin
        $display("FAIL stream_lane_sel[%0d] got %b exp %b", i, lane_sel, (i % 2 == 0)); miscompares++;
      end
    end
    valid = 1'b0;
    tick;
    vectors++;
    if ({validout0, validout1, err_drop} !== 3'b000) begin
      $display("FAIL stream_drain got %b exp 000", {validout0, validout1, err_drop}); miscompares++;
    end
  endtask

  // Pushes A0..A4 with ready1=0: lane 1 ends full with A1,A3 and lane_sel=1.
  task automatic fill_lane1;
    do_reset;
    ready0 = 1'b1; ready1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1; data_in0_demuxL2 = 8'hA0 + 8'(i);
      tick;
    end
    valid = 1'b0;
  endtask

  task automatic test_backpressure;
    fill_lane1;
    vectors++;
    if ({in_ready, lane_sel, validout1, dataout1_demuxL2} !== {1'b0, 1'b1, 1'b1, 8'hA1}) begin
      $display("FAIL bp_full got ir=%b sel=%b v1=%b d1=%h exp 0/1/1/a1",
               in_ready, lane_sel, validout1, dataout1_demuxL2); miscompares++;
    end
    vectors++;
    if ({validout0, dataout0_demuxL2} !== {1'b1, 8'hA4}) begin
      $display("FAIL bp_lane0 got %b/%h exp 1/a4", validout0, dataout0_demuxL2); miscompares++;
    end
    tick;
    vectors++;
    if ({in_ready, dataout1_demuxL2} !== {1'b0, 8'hA1}) begin
      $display("FAIL bp_hold got %b/%h exp 0/a1", in_ready, dataout1_demuxL2); miscompares++;
    end
    ready1 = 1'b1;
    tick;
    vectors++;
    if ({in_ready, dataout1_demuxL2} !== {1'b1, 8'hA3}) begin
      $display("FAIL bp_release got %b/%h exp 1/a3", in_ready, dataout1_demuxL2); miscompares++;
    end
    valid = 1'b1; data_in0_demuxL2 = 8'hA5;
    tick;
    valid = 1'b0;
    vectors++;
    if ({validout1, dataout1_demuxL2, lane_sel} !== {1'b1, 8'hA5, 1'b0}) begin
      $display("FAIL bp_a5 got %b/%h/%b exp 1/a5/0", validout1, dataout1_demuxL2, lane_sel); miscompares++;
    end
    tick;
    vectors++;
    if ({validout1, err_drop} !== 2'b00) begin
      $display("FAIL bp_end got %b exp 00", {validout1, err_drop}); miscompares++;
    end
  endtask

  task automatic test_drop;
    fill_lane1;
    valid = 1'b1; data_in0_demuxL2 = 8'hEE;
    for (int i = 0; i < 2; i++) begin
      tick;
      vectors++;
      if ({err_drop, lane_sel, validout0, dataout1_demuxL2} !== {1'b1, 1'b1, 1'b0, 8'hA1}) begin
        $display("FAIL drop[%0d] got err=%b sel=%b v0=%b d1=%h exp 1/1/0/a1",
                 i, err_drop, lane_sel, validout0, dataout1_demuxL2); miscompares++;
      end
    end
    valid = 1'b0; ready1 = 1'b1;
    tick;
    vectors++;
    if (dataout1_demuxL2 !== 8'hA3) begin
      $display("FAIL drop_drain1 got %h exp a3", dataout1_demuxL2); miscompares++;
    end
    tick;
    vectors++;
    if ({validout1, err_drop} !== 2'b01) begin
      $display("FAIL drop_drain2 got %b exp 01", {validout1, err_drop}); miscompares++;
    end
    valid = 1'b1; data_in0_demuxL2 = 8'h5A;
    tick;
    valid = 1'b0;
    vectors++;
    if ({validout1, dataout1_demuxL2, validout0} !== {1'b1, 8'h5A, 1'b0}) begin
      $display("FAIL drop_phase got %b/%h/%b exp 1/5a/0", validout1, dataout1_demuxL2, validout0); miscompares++;
    end
  endtask

  task automatic test_realign;
    int n;
    logic exp_sel;
    for (int r = 0; r < 2; r++) begin
      n = (r == 0) ? 15 : 14;
      exp_sel = (n < 15);
      do_reset;
      ready0 = 1'b1; ready1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
        valid = 1'b1; data_in0_demuxL2 = 8'h31 + 8'(i);
        tick;
      end
      valid = 1'b0;
      repeat (n) tick;
      vectors++;
      if (lane_sel !== exp_sel) begin
        $display("FAIL realign%0d_sel got %b exp %b", n, lane_sel, exp_sel); miscompares++;
      end
      valid = 1'b1; data_in0_demuxL2 = 8'h55;
      tick;
      valid = 1'b0;
      vectors++;
      if (exp_sel == 1'b0 && {validout0, dataout0_demuxL2, validout1} !== {1'b1, 8'h55, 1'b0}) begin
        $display("FAIL realign%0d_lane0 got %b/%h/%b exp 1/55/0", n, validout0, dataout0_demuxL2, validout1);
        miscompares++;
      end
      if (exp_sel == 1'b1 && {validout1, dataout1_demuxL2, validout0} !== {1'b1, 8'h55, 1'b0}) begin
        $display("FAIL realign%0d_lane1 got %b/%h/%b exp 1/55/0", n, validout1, dataout1_demuxL2, validout0);
        miscompares++;
      end
    end
  endtask

  task automatic test_push_pop;
    logic [7:0] head;
    do_reset;
    ready0 = 1'b0; ready1 = 1'b1;
    valid = 1'b1; data_in0_demuxL2 = 8'h80;
    tick;
    head = 8'h80;
    for (int k = 0; k < 20; k++) begin
      ready0 = 1'b0; data_in0_demuxL2 = 8'hC0 + 8'(k);
      tick;
      vectors++;
      if ({validout0, dataout0_demuxL2, in_ready} !== {1'b1, head, 1'b1}) begin
        $display("FAIL pp_hold[%0d] got %b/%h/%b exp 1/%h/1", k, validout0, dataout0_demuxL2, in_ready, head);
        miscompares++;
      end
      ready0 = 1'b1; data_in0_demuxL2 = 8'h81 + 8'(k);
      tick;
      head = 8'h81 + 8'(k);
      vectors++;
      if ({validout0, dataout0_demuxL2} !== {1'b1, head}) begin
        $display("FAIL pp_swap[%0d] got %b/%h exp 1/%h", k, validout0, dataout0_demuxL2, head);
        miscompares++;
      end
    end
    valid = 1'b0; ready0 = 1'b1;
    tick;
    vectors++;
    if (validout0 !== 1'b0) begin
      $display("FAIL pp_occupancy got %b exp 0", validout0); miscompares++;
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1; data_in0_demuxL2 = 8'h61 + 8'(i);
      tick;
    end
    valid = 1'b0;
    vectors++;
    if ({validout0, dataout0_demuxL2, validout1, lane_sel} !== {1'b1, 8'h61, 1'b1, 1'b1}) begin
      $display("FAIL rstmid_pre got %b/%h/%b/%b exp 1/61/1/1", validout0, dataout0_demuxL2, validout1, lane_sel);
      miscompares++;
    end
    #3 reset_L = 1'b0;
    #1;
    vectors++;
    if ({validout0, validout1, lane_sel, in_ready, err_drop} !== 5'b00010) begin
      $display("FAIL rstmid_flags got %b exp 00010", {validout0, validout1, lane_sel, in_ready, err_drop});
      miscompares++;
    end
    vectors++;
    if ({dataout0_demuxL2, dataout1_demuxL2} !== 16'h0000) begin
      $display("FAIL rstmid_data got %h exp 0000", {dataout0_demuxL2, dataout1_demuxL2}); miscompares++;
    end
    tick;
    reset_L = 1'b1;
  endtask

  initial begin
    reset_L = 1'b0; valid = 1'b0; ready0 = 1'b0; ready1 = 1'b0; data_in0_demuxL2 = '0;
    test_reset;
    test_stream;
    test_backpressure;
    test_drop;
    test_realign;
    test_push_pop;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
